// File: rtl/soc_addr_router.sv
// soc_addr_router: request-side address decoder in front of the SoC crossbar.
// One AR/AW request is decoded against the address map, parked in a single
// stage register, then either presented one-hot routed to a slave port or
// terminated locally by an error responder that returns DECERR beats.
module soc_addr_router #(
  parameter int unsigned NumRules  = 10,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 5,
  // Index i = slave i: DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleBase = {
    64'h0000_0000_0000_0000,  // 9 Debug
    64'h0000_0000_0001_0000,  // 8 ROM
    64'h0000_0000_0200_0000,  // 7 CLINT
    64'h0000_0000_0C00_0000,  // 6 PLIC
    64'h0000_0000_1000_0000,  // 5 UART
    64'h0000_0000_1800_0000,  // 4 Timer
    64'h0000_0000_2000_0000,  // 3 SPI
    64'h0000_0000_3000_0000,  // 2 Ethernet
    64'h0000_0000_4000_0000,  // 1 GPIO
    64'h0000_0000_8000_0000   // 0 DRAM
  },
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleLength = {
    64'h0000_0000_0000_1000,  // 9 Debug
    64'h0000_0000_0001_0000,  // 8 ROM
    64'h0000_0000_000C_0000,  // 7 CLINT
    64'h0000_0000_03FF_FFFF,  // 6 PLIC
    64'h0000_0000_0000_1000,  // 5 UART
    64'h0000_0000_0000_1000,  // 4 Timer
    64'h0000_0000_0080_0000,  // 3 SPI
    64'h0000_0000_0001_0000,  // 2 Ethernet
    64'h0000_0000_0000_1000,  // 1 GPIO
    64'h0000_0000_4000_0000   // 0 DRAM
  }
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [7:0]           req_len_i,
  input  logic                 req_write_i,
  output logic                 mst_valid_o,
  input  logic                 mst_ready_i,
  output logic [NumRules-1:0]  mst_sel_o,
  output logic [AddrWidth-1:0] mst_addr_o,
  output logic [IdWidth-1:0]   mst_id_o,
  output logic [7:0]           mst_len_o,
  output logic                 mst_write_o,
  output logic                 err_valid_o,
  input  logic                 err_ready_i,
  output logic [IdWidth-1:0]   err_id_o,
  output logic                 err_write_o,
  output logic                 err_last_o,
  output logic [1:0]           err_resp_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR_B,
    ST_ERR_R
  } err_state_e;

  // Decode results
  logic [NumRules-1:0]  hit;
  logic [NumRules-1:0]  req_sel;
  logic                 req_miss;

  // Stage register S
  logic                 s_valid_reg;
  logic                 s_miss_reg;
  logic [NumRules-1:0]  s_sel_reg;
  logic [AddrWidth-1:0] s_addr_reg;
  logic [IdWidth-1:0]   s_id_reg;
  logic [7:0]           s_len_reg;
  logic                 s_write_reg;

  // Error responder
  err_state_e           state_reg;
  logic [IdWidth-1:0]   err_id_reg;
  logic [7:0]           err_len_reg;
  logic [7:0]           beat_cnt_reg;

  // Keeps req_ready_o low while reset is asserted
  logic                 rdy_en_reg;

  logic                 req_fire;
  logic                 hold;
  logic                 hit_fire;
  logic                 fsm_done;
  logic                 fsm_free;
  logic                 err_load;
  logic                 s_drain;

  // Per-rule range compare; the end address is formed one bit wider so a rule
  // ending at the top of the address space cannot wrap around.
  generate
    for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
      logic [AddrWidth:0] lo;
      logic [AddrWidth:0] hi;
      assign lo      = {1'b0, RuleBase[gi]};
      assign hi      = {1'b0, RuleBase[gi]} + {1'b0, RuleLength[gi]};
      assign hit[gi] = ({1'b0, req_addr_i} >= lo) && ({1'b0, req_addr_i} < hi);
    end
  endgenerate

  // Lowest-index rule wins when rules overlap
  always_comb begin
    logic found;
    req_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < NumRules; i++) begin
      if (hit[i] && !found) begin
        req_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign req_miss = ~|hit;

  // A routed hit must not overtake an error burst carrying the same ID
  assign hold     = (state_reg != ST_IDLE) && (s_id_reg == err_id_reg);
  assign hit_fire = mst_valid_o && mst_ready_i;

  assign fsm_done = ((state_reg == ST_ERR_B) && err_ready_i) ||
                    ((state_reg == ST_ERR_R) && err_ready_i && (beat_cnt_reg == err_len_reg));
  // Responder can take a new miss when idle or finishing on this very edge
  assign fsm_free = (state_reg == ST_IDLE) || fsm_done;
  assign err_load = s_valid_reg && s_miss_reg && fsm_free;

  assign s_drain     = hit_fire || err_load;
  assign req_ready_o = rdy_en_reg && (!s_valid_reg || s_drain);
  assign req_fire    = req_valid_i && req_ready_o;

  assign mst_valid_o = s_valid_reg && !s_miss_reg && !hold;
  assign mst_sel_o   = s_sel_reg;
  assign mst_addr_o  = s_addr_reg;
  assign mst_id_o    = s_id_reg;
  assign mst_len_o   = s_len_reg;
  assign mst_write_o = s_write_reg;

  assign err_valid_o = (state_reg != ST_IDLE);
  assign err_write_o = (state_reg == ST_ERR_B);
  assign err_last_o  = (state_reg == ST_ERR_B) ||
                       ((state_reg == ST_ERR_R) && (beat_cnt_reg == err_len_reg));
  assign err_id_o    = err_id_reg;
  assign err_resp_o  = 2'b11;

  // Enable request acceptance from the first edge after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_en_reg <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
    end
  end

  // Stage register: load on request handshake, empty when drained
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_valid_reg <= 1'b0;
      s_miss_reg  <= 1'b0;
      s_sel_reg   <= '0;
      s_addr_reg  <= '0;
      s_id_reg    <= '0;
      s_len_reg   <= '0;
      s_write_reg <= 1'b0;
    end else if (req_fire) begin
      s_valid_reg <= 1'b1;
      s_miss_reg  <= req_miss;
      s_sel_reg   <= req_sel;
      s_addr_reg  <= req_addr_i;
      s_id_reg    <= req_id_i;
      s_len_reg   <= req_len_i;
      s_write_reg <= req_write_i;
    end else if (s_drain) begin
      s_valid_reg <= 1'b0;
    end
  end

  // Error responder: one B beat for writes, len+1 R beats for reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_IDLE;
      err_id_reg   <= '0;
      err_len_reg  <= '0;
      beat_cnt_reg <= '0;
    end else if (err_load) begin
      state_reg    <= s_write_reg ? ST_ERR_B : ST_ERR_R;
      err_id_reg   <= s_id_reg;
      err_len_reg  <= s_len_reg;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_ERR_B: begin
          if (err_ready_i) state_reg <= ST_IDLE;
        end
        ST_ERR_R: begin
          if (err_ready_i) begin
            if (beat_cnt_reg == err_len_reg) begin
              state_reg <= ST_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_addr_router.sv
// Bench for soc_addr_router: scoreboard queues of expected routed requests and
// expected error beats, filled when a request is accepted and drained by a
// monitor whenever the DUT completes a handshake.
module tb_soc_addr_router;

  typedef struct packed {
    logic [9:0]  sel;
    logic [63:0] addr;
    logic [4:0]  id;
    logic [7:0]  len;
    logic        wr;
  } mst_exp_t;

  typedef struct packed {
    logic [4:0] id;
    logic       wr;
    logic       last;
  } err_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [4:0]  req_id;
  logic [7:0]  req_len;
  logic        req_write;
  logic        mst_valid;
  logic        mst_ready;
  logic [9:0]  mst_sel;
  logic [63:0] mst_addr;
  logic [4:0]  mst_id;
  logic [7:0]  mst_len;
  logic        mst_write;
  logic        err_valid;
  logic        err_ready;
  logic [4:0]  err_id;
  logic        err_write;
  logic        err_last;
  logic [1:0]  err_resp;

  int n_cmp = 0;
  int n_err = 0;
  int mst_hs = 0;
  int err_hs = 0;
  int last_wait = 0;

  mst_exp_t mst_q[$];
  err_exp_t err_q[$];
  mst_exp_t mon_me;
  err_exp_t mon_ee;

  soc_addr_router dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_id_i    (req_id),
    .req_len_i   (req_len),
    .req_write_i (req_write),
    .mst_valid_o (mst_valid),
    .mst_ready_i (mst_ready),
    .mst_sel_o   (mst_sel),
    .mst_addr_o  (mst_addr),
    .mst_id_o    (mst_id),
    .mst_len_o   (mst_len),
    .mst_write_o (mst_write),
    .err_valid_o (err_valid),
    .err_ready_i (err_ready),
    .err_id_o    (err_id),
    .err_write_o (err_write),
    .err_last_o  (err_last),
    .err_resp_o  (err_resp)
  );

  always #5 clk = ~clk;

  // Monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mst_valid && mst_ready) begin
        mst_hs++;
        n_cmp++;
        if (mst_q.size() == 0) begin
          n_err++;
          $display("FAIL mst_unexpected: got sel=%h addr=%h id=%0d, required no routed request", mst_sel, mst_addr, mst_id);
        end else begin
          mon_me = mst_q.pop_front();
          if ({mst_sel, mst_addr, mst_id, mst_len, mst_write} !== mon_me) begin
            n_err++;
            $display("FAIL mst_route: got sel=%h addr=%h id=%0d len=%0d wr=%b, required sel=%h addr=%h id=%0d len=%0d wr=%b",
                     mst_sel, mst_addr, mst_id, mst_len, mst_write,
                     mon_me.sel, mon_me.addr, mon_me.id, mon_me.len, mon_me.wr);
          end else begin
            $display("mst  sel=%h addr=%h id=%0d len=%0d wr=%b ok", mst_sel, mst_addr, mst_id, mst_len, mst_write);
          end
        end
      end
      if (err_valid && err_ready) begin
        err_hs++;
        n_cmp++;
        if (err_q.size() == 0) begin
          n_err++;
          $display("FAIL err_unexpected: got id=%0d wr=%b last=%b, required no error beat", err_id, err_write, err_last);
        end else begin
          mon_ee = err_q.pop_front();
          if ({err_id, err_write, err_last, err_resp} !== {mon_ee, 2'b11}) begin
            n_err++;
            $display("FAIL err_beat: got id=%0d wr=%b last=%b resp=%b, required id=%0d wr=%b last=%b resp=11",
                     err_id, err_write, err_last, err_resp, mon_ee.id, mon_ee.wr, mon_ee.last);
          end
        end
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, record expectations.
  // exp_sel == 0 means the address is expected to miss the map.
  task automatic send_req(input logic [63:0] a, input logic [4:0] id, input logic [7:0] len,
                          input logic wr, input logic [9:0] exp_sel);
    int t;
    req_valid = 1'b1;
    req_addr  = a;
    req_id    = id;
    req_len   = len;
    req_write = wr;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    last_wait = t;
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_accept: got no acceptance of addr=%h within 600 cycles, required acceptance", a);
    end else if (exp_sel != 10'h000) begin
      mst_q.push_back('{sel: exp_sel, addr: a, id: id, len: len, wr: wr});
    end else if (wr) begin
      err_q.push_back('{id: id, wr: 1'b1, last: 1'b1});
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        err_q.push_back('{id: id, wr: 1'b0, last: (i == int'(len))});
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait until both scoreboards are drained and the DUT is quiet
  task automatic wait_idle(input int budget, input bit rnd_err_ready);
    int t;
    t = 0;
    n_cmp++;
    while (t < budget && !(mst_q.size() == 0 && err_q.size() == 0 && !mst_valid && !err_valid)) begin
      @(posedge clk);
      #1;
      if (rnd_err_ready) err_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    if (t >= budget) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d routed / %0d error beats outstanding, required 0", mst_q.size(), err_q.size());
    end
    err_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_id    = '0;
    req_len   = '0;
    req_write = 1'b0;
    mst_ready = 1'b1;
    err_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 8;
    if (mst_valid !== 1'b0) begin n_err++; $display("FAIL reset_mst_valid: got %b, required 0", mst_valid); end
    if (err_valid !== 1'b0) begin n_err++; $display("FAIL reset_err_valid: got %b, required 0", err_valid); end
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    if (mst_sel !== 10'h000) begin n_err++; $display("FAIL reset_mst_sel: got %h, required 000", mst_sel); end
    if (err_last !== 1'b0) begin n_err++; $display("FAIL reset_err_last: got %b, required 0", err_last); end
    if (err_write !== 1'b0) begin n_err++; $display("FAIL reset_err_write: got %b, required 0", err_write); end
    if (mst_addr !== 64'h0) begin n_err++; $display("FAIL reset_mst_addr: got %h, required 0", mst_addr); end
    if (err_resp !== 2'b11) begin n_err++; $display("FAIL reset_err_resp: got %b, required 11", err_resp); end
    $display("reset checked");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hit_latency();
    mst_ready = 1'b1;
    send_req(64'h0000_0000_8000_0000, 5'd1, 8'd0, 1'b0, 10'h001);
    @(negedge clk);
    n_cmp++;
    if (mst_valid !== 1'b1 || mst_sel !== 10'h001) begin
      n_err++;
      $display("FAIL hit_latency: got valid=%b sel=%h one cycle after accept, required valid=1 sel=001", mst_valid, mst_sel);
    end
    @(posedge clk);
    #1;
    wait_idle(50, 1'b0);
  endtask

  task automatic test_boundaries();
    logic [63:0] ta [0:14];
    logic [9:0]  ts [0:14];
    ta = '{64'h0, 64'h0FFF, 64'h1000, 64'h0001_0000, 64'h0200_0000,
           64'h0FFF_FFFE, 64'h0FFF_FFFF, 64'h1000_0FFF, 64'h1800_0000, 64'h2000_0000,
           64'h3000_FFFF, 64'h4000_0000, 64'hBFFF_FFFF, 64'hC000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    ts = '{10'h200, 10'h200, 10'h000, 10'h100, 10'h080,
           10'h040, 10'h000, 10'h020, 10'h010, 10'h008,
           10'h004, 10'h002, 10'h001, 10'h000, 10'h000};
    mst_ready = 1'b1;
    err_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send_req(ta[i], 5'(i), 8'd0, 1'b0, ts[i]);
    end
    wait_idle(200, 1'b0);
  endtask

  task automatic test_read_miss();
    int start;
    start = err_hs;
    send_req(64'h0000_0000_5000_0000, 5'd3, 8'd3, 1'b0, 10'h000);
    wait_idle(200, 1'b1);
    n_cmp++;
    if (err_hs - start !== 4) begin
      n_err++;
      $display("FAIL read_miss_beats: got %0d beats, required 4", err_hs - start);
    end
  endtask

  task automatic test_write_miss();
    int start;
    start = err_hs;
    err_ready = 1'b1;
    send_req(64'h0000_0000_1000_1000, 5'd8, 8'd0, 1'b1, 10'h000);
    @(negedge clk);
    n_cmp++;
    if (err_valid !== 1'b0) begin n_err++; $display("FAIL err_latency_early: got err_valid=%b 1 cycle after accept, required 0", err_valid); end
    @(negedge clk);
    n_cmp++;
    if (err_valid !== 1'b1 || err_write !== 1'b1 || err_last !== 1'b1) begin
      n_err++;
      $display("FAIL err_latency_b: got valid=%b wr=%b last=%b 2 cycles after accept, required 1 1 1", err_valid, err_write, err_last);
    end
    @(posedge clk);
    #1;
    wait_idle(50, 1'b0);
    n_cmp++;
    if (err_hs - start !== 1) begin
      n_err++;
      $display("FAIL write_miss_beats: got %0d B beats, required 1", err_hs - start);
    end
  endtask

  task automatic test_ordering();
    int start;
    int seen;
    int t;
    bit viol;
    bit during;
    mst_ready = 1'b1;
    err_ready = 1'b1;
    // Same ID: the hit must wait until all 256 error beats are accepted
    start = err_hs;
    seen  = -1;
    viol  = 1'b0;
    send_req(64'h0000_0000_5000_0000, 5'd2, 8'd255, 1'b0, 10'h000);
    send_req(64'h0000_0000_8000_0040, 5'd2, 8'd1, 1'b0, 10'h001);
    t = 0;
    while (t < 400 && (mst_q.size() != 0 || err_q.size() != 0 || mst_valid || err_valid)) begin
      @(negedge clk);
      if (mst_valid && mst_id == 5'd2 && err_valid && err_id == 5'd2) viol = 1'b1;
      if (mst_valid && mst_ready && seen < 0) seen = err_hs - start;
      t++;
    end
    n_cmp += 2;
    if (viol) begin n_err++; $display("FAIL order_hold: got hit id 2 presented during id 2 burst, required held"); end
    if (seen !== 256) begin n_err++; $display("FAIL order_release: got %0d beats before hit, required 256", seen); end
    @(posedge clk);
    #1;
    wait_idle(50, 1'b0);
    // Different ID: the hit routes while the burst is still running
    during = 1'b0;
    seen   = -1;
    send_req(64'h0000_0000_5000_0000, 5'd2, 8'd255, 1'b0, 10'h000);
    send_req(64'h0000_0000_8000_0080, 5'd5, 8'd0, 1'b1, 10'h001);
    t = 0;
    while (t < 20 && seen < 0) begin
      @(negedge clk);
      if (mst_valid && mst_ready) begin
        seen   = t;
        during = err_valid;
      end
      t++;
    end
    n_cmp++;
    if (during !== 1'b1) begin
      n_err++;
      $display("FAIL order_pass: got hit id 5 routed with err_valid=%b after %0d cycles, required during burst", during, seen);
    end
    @(posedge clk);
    #1;
    wait_idle(400, 1'b0);
  endtask

  task automatic test_back_to_back();
    int waits;
    logic [5:0] pat;
    mst_ready = 1'b1;
    err_ready = 1'b1;
    waits = 0;
    send_req(64'h0000_0000_8000_0100, 5'd10, 8'd0, 1'b0, 10'h001);
    waits += last_wait;
    send_req(64'h0000_0000_1000_0004, 5'd11, 8'd3, 1'b1, 10'h020);
    waits += last_wait;
    send_req(64'h0000_0000_4000_0008, 5'd12, 8'd7, 1'b0, 10'h002);
    waits += last_wait;
    send_req(64'h0000_0000_0200_0010, 5'd13, 8'd1, 1'b1, 10'h080);
    waits += last_wait;
    n_cmp++;
    if (waits !== 0) begin n_err++; $display("FAIL b2b_throughput: got %0d stall cycles over 4 hits, required 0", waits); end
    wait_idle(50, 1'b0);
    // Two read misses in a row: the second burst follows with no idle cycle
    send_req(64'h0000_0000_6000_0000, 5'd14, 8'd1, 1'b0, 10'h000);
    send_req(64'h0000_0000_7000_0000, 5'd15, 8'd1, 1'b0, 10'h000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = err_valid;
    end
    n_cmp++;
    if (pat !== 6'b001111) begin n_err++; $display("FAIL b2b_err_reload: got err_valid pattern %b, required 001111", pat); end
    @(posedge clk);
    #1;
    wait_idle(50, 1'b0);
  endtask

  task automatic test_stall_reset();
    int active;
    // Crossbar stall: routed request stays put and nothing new is accepted
    mst_ready = 1'b0;
    send_req(64'h0000_0000_1000_0010, 5'd4, 8'd2, 1'b1, 10'h020);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (mst_valid !== 1'b1 || mst_sel !== 10'h020 || mst_addr !== 64'h1000_0010 || mst_id !== 5'd4 || mst_len !== 8'd2 || mst_write !== 1'b1) begin
        n_err++;
        $display("FAIL stall_stable: got valid=%b sel=%h addr=%h id=%0d len=%0d wr=%b, required 1 020 10000010 4 2 1",
                 mst_valid, mst_sel, mst_addr, mst_id, mst_len, mst_write);
      end
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready: got %b, required 0", req_ready); end
    end
    @(posedge clk);
    #1;
    mst_ready = 1'b1;
    wait_idle(50, 1'b0);
    // Reset in the middle of a burst with a routed request pending
    mst_ready = 1'b0;
    err_ready = 1'b1;
    send_req(64'h0000_0000_5000_0000, 5'd6, 8'd20, 1'b0, 10'h000);
    send_req(64'h0000_0000_8000_1000, 5'd7, 8'd0, 1'b0, 10'h001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (err_valid !== 1'b0) begin n_err++; $display("FAIL rst_err_valid: got %b, required 0", err_valid); end
    if (mst_valid !== 1'b0) begin n_err++; $display("FAIL rst_mst_valid: got %b, required 0", mst_valid); end
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
    mst_q.delete();
    err_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mst_ready = 1'b1;
    active = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (err_valid || mst_valid) active++;
    end
    n_cmp++;
    if (active !== 0) begin n_err++; $display("FAIL rst_no_resume: got %0d active cycles after reset release, required 0", active); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_boundaries();
    test_read_miss();
    test_write_miss();
    test_ordering();
    test_back_to_back();
    test_stall_reset();
    // A fresh request after the mid-burst reset still routes correctly
    test_hit_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
